// File: rtl/wishbus_sram_if.sv
// Wishbone classic bus bundle between a master and the wishbus_sram slave.
interface wishbus_sram_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) ();
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [DATA_W/8-1:0]   sel;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdat;
  logic [DATA_W-1:0]     rdat;
  logic                  ack;
  logic                  err;

  modport master (
    output cyc, stb, we, sel, addr, wdat,
    input  rdat, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, addr, wdat,
    output rdat, ack, err
  );
endinterface

// File: rtl/wishbus_sram.sv
// Single-port SRAM behind a classic Wishbone slave: programmable wait states,
// byte-enabled writes and a one-cycle error pulse for addresses >= DEPTH.
module wishbus_sram #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  wishbus_sram_if.slave bus
);
  localparam int unsigned SelW     = DATA_W / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntInit  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StErr} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [SelW-1:0]     sel_q;
  logic [DATA_W-1:0]   wdat_q;
  logic [DATA_W-1:0]   rdat_q;
  logic                ack_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                req;
  logic                in_range;
  logic                enter_ack;
  logic                mem_wr;
  logic [ADDR_W-1:0]   op_addr;
  logic                op_we;
  logic [SelW-1:0]     op_sel;
  logic [DATA_W-1:0]   op_wdat;
  logic [IdxW-1:0]     op_idx;

  // Operands come straight from the bus when ACK is entered from IDLE (no wait
  // states), otherwise from the registers captured in IDLE.
  always_comb begin
    req       = bus.cyc & bus.stb;
    in_range  = {1'b0, bus.addr} < DepthLim;
    op_addr   = (state_q == StIdle) ? bus.addr : addr_q;
    op_we     = (state_q == StIdle) ? bus.we   : we_q;
    op_sel    = (state_q == StIdle) ? bus.sel  : sel_q;
    op_wdat   = (state_q == StIdle) ? bus.wdat : wdat_q;
    op_idx    = op_addr[IdxW-1:0];
    enter_ack = ((state_q == StIdle) && req && in_range && (WAIT_STATES == 0)) ||
                ((state_q == StWait) && bus.cyc && (cnt_q == 4'd0));
    // A reset arriving on the same edge must not let the write through.
    mem_wr    = enter_ack & op_we & ~rst_i;
  end

  // Storage array: byte-enabled write on the edge that enters ACK.
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      for (int unsigned k = 0; k < SelW; k++) begin
        if (op_sel[k]) mem[op_idx][8*k +: 8] <= op_wdat[8*k +: 8];
      end
    end
  end

  // Control FSM with registered ack/err/read-data outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (enter_ack && !op_we) rdat_q <= mem[op_idx];
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q <= bus.addr;
            we_q   <= bus.we;
            sel_q  <= bus.sel;
            wdat_q <= bus.wdat;
            if (!in_range) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state_q <= StAck;
              ack_q   <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (!bus.cyc) begin
            state_q <= StIdle;
          end else if (cnt_q == 4'd0) begin
            state_q <= StAck;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StAck:   state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rdat = rdat_q;
  assign bus.ack  = ack_q;
  assign bus.err  = err_q;
endmodule
